// File: rtl/rot_pkg.sv
// Shared types and sizes for the rotate sequencer and its output register.
package rot_pkg;
    localparam int W   = 8;
    localparam int SHW = $clog2(W);

    typedef enum logic {IDLE, RUN} rot_seq_state_e;
    typedef logic [W-1:0]   rot_word_t;
    typedef logic [SHW-1:0] rot_amt_t;
endpackage

// File: rtl/rotate_seq_if.sv
// Command and result streams of rotate_seq; out_par exists only with ROT_SEQ_PARITY_EN.
interface rotate_seq_if;
    import rot_pkg::*;

    logic      in_valid;
    logic      in_ready;
    rot_word_t in_data;
    rot_amt_t  in_start;
    rot_amt_t  in_len;
    logic      in_dir;
    logic      out_valid;
    logic      out_ready;
    rot_word_t out_data;
    rot_amt_t  out_amt;
    logic      out_last;
    logic      busy;
`ifdef ROT_SEQ_PARITY_EN
    logic      out_par;
`endif

    modport slave (
        input  in_valid, in_data, in_start, in_len, in_dir, out_ready,
        output in_ready, out_valid, out_data, out_amt, out_last, busy
`ifdef ROT_SEQ_PARITY_EN
        , output out_par
`endif
    );

    modport master (
        output in_valid, in_data, in_start, in_len, in_dir, out_ready,
        input  in_ready, out_valid, out_data, out_amt, out_last, busy
`ifdef ROT_SEQ_PARITY_EN
        , input out_par
`endif
    );
endinterface

// File: rtl/rot_seq_outreg.sv
// One-deep valid/ready result register; computes its own load/accept handshake.
// With ROT_SEQ_PARITY_EN it also holds the parity of the stored word.
module rot_seq_outreg
    import rot_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      req_i,
    input  logic      ready_i,
    input  rot_word_t data_i,
    input  rot_amt_t  amt_i,
    input  logic      last_i,
    output logic      load_o,
    output logic      valid_o,
    output rot_word_t data_o,
    output rot_amt_t  amt_o,
    output logic      last_o
`ifdef ROT_SEQ_PARITY_EN
    , output logic    par_o
`endif
);
    logic      valid_q, valid_d;
    rot_word_t data_q, data_d;
    rot_amt_t  amt_q, amt_d;
    logic      last_q, last_d;

    // A new beat may enter when empty or when the held beat leaves this cycle.
    assign load_o = req_i & (~valid_q | ready_i);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        amt_d   = amt_q;
        last_d  = last_q;
        if (load_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
            amt_d   = amt_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            last_q  <= last_d;
        end
    end

`ifdef ROT_SEQ_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         par_q <= 1'b0;
        else if (load_o) par_q <= ^data_i;
    end
    assign par_o = par_q;
`endif

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign last_o  = last_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (valid_q && !ready_i) |=> (valid_q && $stable(data_q) && $stable(amt_q) && $stable(last_q)));
endmodule

// File: rtl/rotate_seq.sv
// Command sequencer feeding an external 8-bit rotator one amount per cycle and
// registering each result as a stream beat. ROT_SEQ_PARITY_EN adds out_par.
module rotate_seq
    import rot_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    rotate_seq_if.slave bus,
    output rot_word_t  rot_a,
    output rot_amt_t   rot_ctrl,
    output logic       rot_dir,
    input  rot_word_t  rot_out
);
    rot_seq_state_e state_q, state_d;
    rot_word_t      data_q, data_d;
    rot_amt_t       amt_q, amt_d;
    rot_amt_t       remain_q, remain_d;
    logic           dir_q, dir_d;
    logic           req, load, out_valid;

    assign req = (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        amt_d    = amt_q;
        remain_d = remain_q;
        dir_d    = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = RUN;
                    data_d   = bus.in_data;
                    amt_d    = bus.in_start;
                    remain_d = bus.in_len;
                    dir_d    = bus.in_dir;
                end
            end
            RUN: begin
                // Without a load everything holds, so the rotator inputs freeze under stall.
                if (load) begin
                    amt_d    = amt_q + rot_amt_t'(1);
                    remain_d = remain_q - rot_amt_t'(1);
                    if (remain_q == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            amt_q    <= '0;
            remain_q <= '0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            amt_q    <= amt_d;
            remain_q <= remain_d;
            dir_q    <= dir_d;
        end
    end

    rot_seq_outreg u_outreg (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .ready_i (bus.out_ready),
        .data_i  (rot_out),
        .amt_i   (amt_q),
        .last_i  (remain_q == '0),
        .load_o  (load),
        .valid_o (out_valid),
        .data_o  (bus.out_data),
        .amt_o   (bus.out_amt),
        .last_o  (bus.out_last)
`ifdef ROT_SEQ_PARITY_EN
        , .par_o (bus.out_par)
`endif
    );

    assign bus.out_valid = out_valid;
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = req | out_valid;

    assign rot_a    = data_q;
    assign rot_ctrl = amt_q;
    assign rot_dir  = dir_q;
endmodule

// File: tb/tb_rotate_seq.sv
// Scoreboard bench for rotate_seq with a behavioural rotator (dir=1 rotates right).
module tb_rotate_seq;
    import rot_pkg::*;

    typedef struct packed {
        rot_word_t d;
        rot_amt_t  a;
        logic      l;
    } beat_t;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    rot_word_t rot_a;
    rot_amt_t  rot_ctrl;
    logic      rot_dir;
    rot_word_t rot_out;
    logic [2*W-1:0] dbl_r, dbl_l;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;

    rotate_seq_if bus();

    rotate_seq dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rot_a    (rot_a),
        .rot_ctrl (rot_ctrl),
        .rot_dir  (rot_dir),
        .rot_out  (rot_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        dbl_r = {rot_a, rot_a} >> rot_ctrl;
        dbl_l = {rot_a, rot_a} << rot_ctrl;
        rot_out = rot_dir ? dbl_r[W-1:0] : dbl_l[2*W-1:W];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input rot_word_t d, input rot_amt_t a, input logic l);
        beat_t b;
        b.d = d; b.a = a; b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input rot_word_t d, input rot_amt_t s, input rot_amt_t len, input logic dir);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_start = s;
        bus.in_len   = len;
        bus.in_dir   = dir;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_not_busy", bus.busy, 1'b0);
    endtask

    task automatic push_case1();
        push(8'h19, 3'd0, 1'b0);
        push(8'h8C, 3'd1, 1'b0);
        push(8'h46, 3'd2, 1'b0);
        push(8'h23, 3'd3, 1'b1);
    endtask

    // Monitor: every handshake beat is popped and compared against the queue head.
    always @(negedge clk) begin : mon
        beat_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h amt %0h last %0b, expected none",
                         bus.out_data, bus.out_amt, bus.out_last);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", bus.out_data, e.d);
                chk("beat_amt", bus.out_amt, e.a);
                chk("beat_last", bus.out_last, e.l);
`ifdef ROT_SEQ_PARITY_EN
                chk("beat_par", bus.out_par, ^e.d);
`endif
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_start  = '0;
        bus.in_len    = '0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_out_amt", bus.out_amt, 3'd0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_rot_a", rot_a, 8'h00);
        chk("rst_rot_ctrl", rot_ctrl, 3'd0);
        chk("rst_rot_dir", rot_dir, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef ROT_SEQ_PARITY_EN
        chk("rst_out_par", bus.out_par, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Case 1: basic four-beat right rotate.
        push_case1();
        send(8'h19, 3'd0, 3'd3, 1'b1);
        chk("t1_in_ready_run", bus.in_ready, 1'b0);
        tick();
        chk("t1_first_valid", bus.out_valid, 1'b1);
        tick();
        tick();
        chk("t1_in_ready_before_last", bus.in_ready, 1'b0);
        tick();
        chk("t1_in_ready_after_last", bus.in_ready, 1'b1);
        drain();

        // Case 2: amount wraps 7 -> 0.
        push(8'h32, 3'd7, 1'b0);
        push(8'h19, 3'd0, 1'b1);
        send(8'h19, 3'd7, 3'd1, 1'b1);
        drain();

        // Case 3: three stall cycles while 8C is held.
        push_case1();
        send(8'h19, 3'd0, 3'd3, 1'b1);
        tick();
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_valid_held", bus.out_valid, 1'b1);
            chk("t3_data_held", bus.out_data, 8'h8C);
            chk("t3_amt_held", bus.out_amt, 3'd1);
            chk("t3_rot_ctrl_frozen", rot_ctrl, 3'd2);
        end
        bus.out_ready = 1'b1;
        drain();

        // Case 4: full sweep; a command offered during RUN must be ignored.
        push(8'h19, 3'd0, 1'b0);
        push(8'h8C, 3'd1, 1'b0);
        push(8'h46, 3'd2, 1'b0);
        push(8'h23, 3'd3, 1'b0);
        push(8'h91, 3'd4, 1'b0);
        push(8'hC8, 3'd5, 1'b0);
        push(8'h64, 3'd6, 1'b0);
        push(8'h32, 3'd7, 1'b1);
        send(8'h19, 3'd0, 3'd7, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t4_beat_each_cycle", bus.out_valid, 1'b1);
            if (i == 2) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'hAA;
                bus.in_start = 3'd5;
                bus.in_len   = 3'd2;
                bus.in_dir   = 1'b0;
            end
            if (i == 3) chk("t4_in_ready_run", bus.in_ready, 1'b0);
            if (i == 4) bus.in_valid = 1'b0;
        end
        drain();

        // Case 5: asynchronous reset after beat 2, then a fresh command.
        push_case1();
        send(8'h19, 3'd0, 3'd3, 1'b1);
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        chk("t5_valid_dropped", bus.out_valid, 1'b0);
        chk("t5_in_ready_async", bus.in_ready, 1'b1);
        chk("t5_busy_cleared", bus.busy, 1'b0);
        chk("t5_no_last", bus.out_last, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        push_case1();
        send(8'h19, 3'd0, 3'd3, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
